dec5to20_rx: RTL
================

Name: dec5to20_rx

Overview:
- Receive side of the 20-to-5 priority encoder link: accepts a 5-bit code plus strobe from the encoder side and reconstructs a registered 20-bit one-hot line.
- Synchronizes the inputs, debounces the strobe and code, and rejects out-of-range codes.
- Reports each accepted event with a valid pulse and keeps a saturating event counter for the keypad/status logic downstream.

Parameters:
- NUM_OUT, 20: width of the one-hot output; legal codes are 0..NUM_OUT-1.
- CODE_W, 5: width of the code input; must satisfy 2**CODE_W >= NUM_OUT.
- DEBOUNCE_CYCLES, 4: number of consecutive stable cycles required before a code is accepted; must be >= 2.
- CNT_W, 8: width of the accepted-event counter.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- code_in  in  CODE_W  code from the encoder; asynchronous to clk.
- strobe_in  in  1  encoder strobe, high while any input is active; asynchronous.
- clr  in  1  synchronous clear of onehot_out and event_cnt.
- onehot_out  out  NUM_OUT  decoded one-hot, registered.
- valid  out  1  one-cycle pulse when a legal code is accepted.
- err  out  1  one-cycle pulse when an out-of-range code is accepted.
- busy  out  1  high whenever the FSM is not in IDLE.
- event_cnt  out  CNT_W  count of legal accepts; saturates at all-ones.

Behaviour:
- Reset (nrst low, asynchronous):
  - State = IDLE.
  - onehot_out = 0, valid = 0, err = 0, busy = 0, event_cnt = 0.
  - Synchronizer flops = 0, debounce counter = 0.
- Synchronizer: strobe_in and code_in each pass through two flops, giving s_strobe and s_code. Edge k is the first edge that samples strobe_in high; s_strobe is visible after edge k+1.
- FSM states: IDLE, DEBOUNCE, HOLD.
- IDLE: if s_strobe = 1, capture cap_code = s_code, set cnt = 1, and go to DEBOUNCE.
- DEBOUNCE:
  - If s_strobe = 0 or s_code != cap_code: go to IDLE and set cnt = 0. No output change.
  - Else if cnt = DEBOUNCE_CYCLES-1: accept and go to HOLD.
  - Else cnt = cnt+1.
- Accept, on the transition edge:
  - If cap_code < NUM_OUT: onehot_out = 1 << cap_code, valid = 1 for one cycle, event_cnt increments (holds if already all-ones).
  - If cap_code >= NUM_OUT: err = 1 for one cycle; onehot_out and event_cnt unchanged.
- Latency: the accept takes effect at edge k+DEBOUNCE_CYCLES+1, which is edge k+5 at the defaults.
- HOLD:
  - Code changes are ignored.
  - When s_strobe = 0, go to IDLE.
  - A new event requires strobe to go low and then high again.
- clr:
  - Clears onehot_out and event_cnt on the next edge.
  - If clr and an accept occur on the same edge, the accept wins: onehot_out = new value and event_cnt = 1. An invalid accept with clr leaves both cleared and still pulses err.
  - clr does not affect FSM state.
- busy = (state != IDLE), driven combinationally from the state register.
- Reset during DEBOUNCE or HOLD aborts the event; no valid or err is produced.
- A strobe-high time shorter than DEBOUNCE_CYCLES+1 cycles, or a code changing during debounce, never produces valid.
- Back-to-back events need at least one s_strobe-low cycle, which is observed in HOLD, plus the full debounce period.

Optional Feature:
- Macro DEC5TO20_PULSE_OUT_EN.
- Defined: onehot_out carries the decoded value only in the cycle valid is high and is 0 otherwise. clr has no effect on onehot_out in this mode.
- Undefined (default): onehot_out latches the last legal code until the next legal accept, clr, or reset.

Test Plan:
- Reset, then code_in=5'd0 with strobe_in=1 held 10 cycles -> valid pulse at edge k+5; onehot_out=20'h00001; event_cnt=1; busy low after strobe drops plus 2 cycles.
- code_in=5'd19, strobe held -> onehot_out=20'h80000 and valid=1. Then code_in=5'd20, strobe released and re-asserted -> err pulse, onehot_out stays 20'h80000, event_cnt unchanged.
- strobe_in high for only 3 cycles with code 5'd7 -> no valid, no err; onehot_out unchanged. Also: code changes from 7 to 8 at debounce cycle 2 with strobe held -> FSM restarts and accepts 8.
- clr asserted on the same edge as the accept of code 5'd3 -> onehot_out=20'h00008 and event_cnt=1. clr alone later -> onehot_out=0 and event_cnt=0.
- nrst pulsed low mid-DEBOUNCE -> all outputs 0 immediately; no valid after release even though strobe stays high until it drops and rises again. With CNT_W=2, 5 legal events -> event_cnt=3 (saturated).
- With DEC5TO20_PULSE_OUT_EN defined, code 5'd10 -> onehot_out=20'h00400 for exactly one cycle, coincident with valid, then 0.

Source files
------------

// File: rtl/dec5to20_rx.sv
// Receive side of the 20-to-5 priority encoder link: synchronizes code/strobe,
// debounces them, and turns each stable event into a registered one-hot line,
// a valid/err pulse and a saturating event count.
// Optional build macro: DEC5TO20_PULSE_OUT_EN makes onehot_out a one-cycle pulse
// coincident with valid (clr then has no effect on it); otherwise the last legal
// code is latched.
module dec5to20_rx #(
  parameter int unsigned NUM_OUT         = 20,
  parameter int unsigned CODE_W          = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               strobe_in,
  input  logic               clr,
  output logic [NUM_OUT-1:0] onehot_out,
  output logic               valid,
  output logic               err,
  output logic               busy,
  output logic [CNT_W-1:0]   event_cnt
);

  localparam int unsigned      DbW    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0]   DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CODE_W:0]  NumOut = (CODE_W + 1)'(NUM_OUT);

  typedef enum logic [1:0] {StIdle, StDebounce, StHold} state_e;

  logic              strobe_s1_q, strobe_s2_q;
  logic [CODE_W-1:0] code_s1_q, code_s2_q;
  logic [1:0]        fill_q;

  state_e            state_q, state_d;
  logic [DbW-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0] cap_q, cap_d;
  logic              arm_q, arm_d;
  logic [NUM_OUT-1:0] onehot_q, onehot_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  event_cnt_q, event_cnt_d;

  logic              accept;
  logic              legal;
  logic [NUM_OUT-1:0] dec;

  // Two-flop synchronizers; fill_q marks when the second stage holds a real sample.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      strobe_s1_q <= 1'b0;
      strobe_s2_q <= 1'b0;
      code_s1_q   <= '0;
      code_s2_q   <= '0;
      fill_q      <= '0;
    end else begin
      strobe_s1_q <= strobe_in;
      strobe_s2_q <= strobe_s1_q;
      code_s1_q   <= code_in;
      code_s2_q   <= code_s1_q;
      fill_q      <= {fill_q[0], 1'b1};
    end
  end

  // Debounce FSM next state; arm_q forces a fresh strobe assertion after reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    arm_d   = arm_q;
    accept  = 1'b0;
    if (fill_q[1] && !strobe_s2_q) arm_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (strobe_s2_q && arm_q) begin
          cap_d   = code_s2_q;
          cnt_d   = DbW'(1);
          state_d = StDebounce;
        end
      end
      StDebounce: begin
        if (!strobe_s2_q || (code_s2_q != cap_q)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == DbLast) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + DbW'(1);
        end
      end
      StHold: begin
        if (!strobe_s2_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output next state; an accept on the same edge as clr takes priority.
  always_comb begin
    legal   = ({1'b0, cap_q} < NumOut);
    dec     = NUM_OUT'(1) << cap_q;
    valid_d = accept && legal;
    err_d   = accept && !legal;
`ifdef DEC5TO20_PULSE_OUT_EN
    onehot_d = valid_d ? dec : '0;
`else
    onehot_d = onehot_q;
    if (clr) onehot_d = '0;
    if (valid_d) onehot_d = dec;
`endif
    event_cnt_d = event_cnt_q;
    if (clr) event_cnt_d = '0;
    if (valid_d) begin
      if (clr) event_cnt_d = CNT_W'(1);
      else if (!(&event_cnt_q)) event_cnt_d = event_cnt_q + CNT_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cap_q       <= '0;
      arm_q       <= 1'b0;
      onehot_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      arm_q       <= arm_d;
      onehot_q    <= onehot_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign onehot_out = onehot_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign event_cnt  = event_cnt_q;
  assign busy       = (state_q != StIdle);

endmodule
